// File: rtl/pc_fetch_gen.sv
//------------------------------------------------------------------------------
// pc_fetch_gen
//   Next-PC generator for the core front end. Owns the fetch PC and presents
//   a valid/ready request to instruction memory. Supports sequential +2/+4
//   increment, prioritised trap/branch redirects, stall back-pressure, a
//   one-entry pending-redirect buffer and a kill flag for stale fetches.
//
// Optional feature macro: PC_MISALIGN_CHK_EN
//   When defined, misaligned branch targets are dropped and reported on
//   o_misalign / o_misalign_addr. When undefined, low bits are silently cleared.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_stall             IF back-pressure, suppresses new requests only
//   i_inc_half          last accepted instruction was compressed (+2)
//   i_redirect_valid/pc branch/jump redirect from EX
//   i_trap_valid/pc     trap/mret redirect from CSR unit
//   o_req_valid/addr    fetch request to instruction memory
//   i_req_ready         memory accepts the request
//   o_req_kill          accepted request is stale, IF drops its response
//   o_misalign(_addr)   (optional) misaligned branch report
//   o_pc_curr           current fetch PC
//------------------------------------------------------------------------------
module pc_fetch_gen #(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h4000_0000,
  parameter bit                 C_EXT    = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_inc_half,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  output logic            o_req_valid,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_req_ready,
  output logic            o_req_kill,
`ifdef PC_MISALIGN_CHK_EN
  output logic            o_misalign,
  output logic [XLEN-1:0] o_misalign_addr,
`endif
  output logic [XLEN-1:0] o_pc_curr
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  // Clear the bits that cannot be set in a legal fetch address.
  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] addr);
    logic [XLEN-1:0] res;
    res    = addr;
    res[0] = 1'b0;
    if (!C_EXT) begin
      res[1] = 1'b0;
    end else begin
      res[1] = addr[1];
    end
    return res;
  endfunction

  state_t          state_r, state_n;
  logic [XLEN-1:0] pc_r, pc_n;
  logic            req_valid_r;
  logic            pend_valid_r, pend_valid_n;
  logic            pend_trap_r, pend_trap_n;
  logic [XLEN-1:0] pend_pc_r, pend_pc_n;
  logic            kill_owed_r, kill_owed_n;
  logic            accept_s;
  logic            redir_ok_s;
  logic [XLEN-1:0] inc_s;
  logic [XLEN-1:0] trap_tgt_s;
  logic [XLEN-1:0] redir_tgt_s;

`ifdef PC_MISALIGN_CHK_EN
  // A branch target is illegal when it has bits set that alignment would drop.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[0] | (C_EXT ? 1'b0 : addr[1]);
  endfunction

  logic            redir_bad_s;
  logic            misalign_r;
  logic [XLEN-1:0] misalign_addr_r;

  assign redir_bad_s = i_redirect_valid & is_misaligned(i_redirect_pc);
  assign redir_ok_s  = i_redirect_valid & ~redir_bad_s;

  // Misalign report: one-cycle pulse plus the raw offending target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      misalign_r      <= 1'b0;
      misalign_addr_r <= {XLEN{1'b0}};
    end else begin
      misalign_r <= redir_bad_s;
      if (redir_bad_s) begin
        misalign_addr_r <= i_redirect_pc;
      end
    end
  end

  assign o_misalign      = misalign_r;
  assign o_misalign_addr = misalign_addr_r;
`else
  assign redir_ok_s = i_redirect_valid;
`endif

  assign accept_s    = (state_r == ST_REQ) & i_req_ready;
  assign inc_s       = (C_EXT && i_inc_half) ? XLEN'(3'd2) : XLEN'(3'd4);
  assign trap_tgt_s  = align_addr(i_trap_pc);
  assign redir_tgt_s = align_addr(i_redirect_pc);

  // Next-state, next-PC and pending-buffer decisions.
  always_comb begin
    state_n      = state_r;
    pc_n         = pc_r;
    pend_valid_n = pend_valid_r;
    pend_trap_n  = pend_trap_r;
    pend_pc_n    = pend_pc_r;
    kill_owed_n  = kill_owed_r;
    case (state_r)
      ST_BOOT, ST_IDLE: begin
        if (state_r == ST_BOOT) begin
          state_n = ST_REQ;
        end else if (!i_stall) begin
          state_n = ST_REQ;
        end else begin
          state_n = ST_IDLE;
        end
        // No request is outstanding, so targets load straight into the PC.
        if (i_trap_valid) begin
          pc_n = trap_tgt_s;
        end else if (redir_ok_s) begin
          pc_n = redir_tgt_s;
        end else begin
          pc_n = pc_r;
        end
      end
      ST_REQ: begin
        if (i_req_ready) begin
          state_n      = i_stall ? ST_IDLE : ST_REQ;
          pend_valid_n = 1'b0;
          pend_trap_n  = 1'b0;
          kill_owed_n  = 1'b0;
          if (i_trap_valid) begin
            pc_n = trap_tgt_s;
          end else if (pend_valid_r && pend_trap_r) begin
            pc_n = pend_pc_r;
          end else if (redir_ok_s) begin
            pc_n = redir_tgt_s;
          end else if (pend_valid_r) begin
            pc_n = pend_pc_r;
          end else begin
            pc_n = pc_r + inc_s;
          end
        end else begin
          // Request held stable; park the target and mark this request stale.
          state_n = ST_REQ;
          if (i_trap_valid) begin
            pend_valid_n = 1'b1;
            pend_trap_n  = 1'b1;
            pend_pc_n    = trap_tgt_s;
            kill_owed_n  = 1'b1;
          end else if (redir_ok_s) begin
            kill_owed_n = 1'b1;
            if (pend_valid_r && pend_trap_r) begin
              pend_valid_n = pend_valid_r;
            end else begin
              pend_valid_n = 1'b1;
              pend_trap_n  = 1'b0;
              pend_pc_n    = redir_tgt_s;
            end
          end else begin
            kill_owed_n = kill_owed_r;
          end
        end
      end
      default: begin
        state_n      = ST_BOOT;
        pc_n         = RESET_PC;
        pend_valid_n = 1'b0;
        pend_trap_n  = 1'b0;
        kill_owed_n  = 1'b0;
      end
    endcase
  end

  // State, PC and pending-buffer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      req_valid_r  <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_trap_r  <= 1'b0;
      pend_pc_r    <= {XLEN{1'b0}};
      kill_owed_r  <= 1'b0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      req_valid_r  <= (state_n == ST_REQ);
      pend_valid_r <= pend_valid_n;
      pend_trap_r  <= pend_trap_n;
      pend_pc_r    <= pend_pc_n;
      kill_owed_r  <= kill_owed_n;
    end
  end

  assign o_req_valid = req_valid_r;
  assign o_req_addr  = pc_r;
  assign o_pc_curr   = pc_r;
  assign o_req_kill  = accept_s & kill_owed_r;

endmodule

// File: tb/tb_pc_fetch_gen.sv
//------------------------------------------------------------------------------
// tb_pc_fetch_gen
//   Directed bench for pc_fetch_gen. Two instances share stimulus: u1 with the
//   compressed extension enabled, u0 with it disabled. Inputs change on the
//   falling edge; outputs are checked 1 ns later.
//------------------------------------------------------------------------------
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, inc_half = 1'b0, ready = 1'b0;
  logic        rv = 1'b0, tv = 1'b0;
  logic [31:0] rpc = 32'h0, tpc = 32'h0;
  logic        v1, k1, v0, k0;
  logic [31:0] a1, p1, a0, p0;
`ifdef PC_MISALIGN_CHK_EN
  logic        m1, m0;
  logic [31:0] ma1, ma0;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_gen #(.XLEN(32), .RESET_PC(32'h4000_0000), .C_EXT(1'b1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_inc_half(inc_half),
    .i_redirect_valid(rv), .i_redirect_pc(rpc), .i_trap_valid(tv), .i_trap_pc(tpc),
    .o_req_valid(v1), .o_req_addr(a1), .i_req_ready(ready), .o_req_kill(k1),
`ifdef PC_MISALIGN_CHK_EN
    .o_misalign(m1), .o_misalign_addr(ma1),
`endif
    .o_pc_curr(p1));

  pc_fetch_gen #(.XLEN(32), .RESET_PC(32'h4000_0000), .C_EXT(1'b0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_inc_half(inc_half),
    .i_redirect_valid(rv), .i_redirect_pc(rpc), .i_trap_valid(tv), .i_trap_pc(tpc),
    .o_req_valid(v0), .o_req_addr(a0), .i_req_ready(ready), .o_req_kill(k0),
`ifdef PC_MISALIGN_CHK_EN
    .o_misalign(m0), .o_misalign_addr(ma0),
`endif
    .o_pc_curr(p0));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b0; stall = 1'b0; inc_half = 1'b0; rv = 1'b0; tv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
    #1;
    total++; if (p1 !== 32'h4000_0000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", p1, 32'h4000_0000); end
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", v1); end
    total++; if (k1 !== 1'b0) begin bad++; $display("FAIL rst_kill got=%b exp=0", k1); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", v1); end
    @(negedge clk); #1;
    total++; if (v1 !== 1'b1 || a1 !== 32'h4000_0000) begin bad++; $display("FAIL seq0 got=%b/%h exp=1/40000000", v1, a1); end
    @(negedge clk); #1;
    total++; if (a1 !== 32'h4000_0004) begin bad++; $display("FAIL seq1 got=%h exp=40000004", a1); end
    @(negedge clk); #1;
    total++; if (a1 !== 32'h4000_0008 || a0 !== 32'h4000_0008) begin bad++; $display("FAIL seq2 got=%h/%h exp=40000008", a1, a0); end
  endtask

  task automatic test_inc_half();
    do_reset();
    @(negedge clk);
    ready = 1'b1; inc_half = 1'b1;
    #1;
    total++; if (a1 !== 32'h4000_0000) begin bad++; $display("FAIL half_pre got=%h exp=40000000", a1); end
    @(negedge clk);
    ready = 1'b0; inc_half = 1'b0;
    #1;
    total++; if (a1 !== 32'h4000_0002) begin bad++; $display("FAIL half_c1 got=%h exp=40000002", a1); end
    total++; if (a0 !== 32'h4000_0004) begin bad++; $display("FAIL half_c0 got=%h exp=40000004", a0); end
  endtask

  task automatic test_pending_kill();
    @(negedge clk);
    ready = 1'b1; rv = 1'b1; rpc = 32'h4000_0010;
    #1;
    total++; if (k1 !== 1'b0) begin bad++; $display("FAIL samecyc_kill got=%b exp=0", k1); end
    @(negedge clk);
    ready = 1'b0; rv = 1'b1; rpc = 32'h4000_0100;
    #1;
    total++; if (a1 !== 32'h4000_0010 || v1 !== 1'b1) begin bad++; $display("FAIL hold_c1 got=%b/%h exp=1/40000010", v1, a1); end
    @(negedge clk);
    rv = 1'b0;
    #1;
    total++; if (a1 !== 32'h4000_0010) begin bad++; $display("FAIL hold_c2 got=%h exp=40000010", a1); end
    @(negedge clk); #1;
    total++; if (a1 !== 32'h4000_0010 || v1 !== 1'b1) begin bad++; $display("FAIL hold_c3 got=%b/%h exp=1/40000010", v1, a1); end
    @(negedge clk);
    ready = 1'b1;
    #1;
    total++; if (k1 !== 1'b1 || k0 !== 1'b1) begin bad++; $display("FAIL stale_kill got=%b/%b exp=1", k1, k0); end
    @(negedge clk);
    ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h4000_0100 || k1 !== 1'b0) begin bad++; $display("FAIL redir_load got=%h/%b exp=40000100/0", a1, k1); end
  endtask

  task automatic test_trap_idle();
    @(negedge clk);
    ready = 1'b1; stall = 1'b1;
    @(negedge clk);
    ready = 1'b0; tv = 1'b1; tpc = 32'h0000_0080; rv = 1'b1; rpc = 32'h4000_0200;
    #1;
    total++; if (v1 !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b exp=0", v1); end
    @(negedge clk);
    tv = 1'b0; rv = 1'b0; stall = 1'b0;
    #1;
    total++; if (p1 !== 32'h0000_0080 || v1 !== 1'b0 || k1 !== 1'b0) begin bad++; $display("FAIL idle_trap got=%h/%b/%b exp=00000080/0/0", p1, v1, k1); end
    @(negedge clk); #1;
    total++; if (v1 !== 1'b1 || a1 !== 32'h0000_0080) begin bad++; $display("FAIL idle_req got=%b/%h exp=1/00000080", v1, a1); end
  endtask

  task automatic test_pending_trap();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0; tv = 1'b1; tpc = 32'h0000_0080;
    #1;
    total++; if (a1 !== 32'h0000_0084) begin bad++; $display("FAIL ptrap_addr got=%h exp=00000084", a1); end
    @(negedge clk);
    tv = 1'b0; rv = 1'b1; rpc = 32'h4000_0300;
    @(negedge clk);
    rv = 1'b0; ready = 1'b1;
    #1;
    total++; if (k1 !== 1'b1 || a1 !== 32'h0000_0084) begin bad++; $display("FAIL ptrap_kill got=%b/%h exp=1/00000084", k1, a1); end
    @(negedge clk); #1;
    total++; if (a1 !== 32'h0000_0080 || a0 !== 32'h0000_0080) begin bad++; $display("FAIL ptrap_win got=%h/%h exp=00000080", a1, a0); end
    total++; if (k1 !== 1'b0) begin bad++; $display("FAIL ptrap_nokill got=%b exp=0", k1); end
    @(negedge clk);
    ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h0000_0084) begin bad++; $display("FAIL ptrap_empty got=%h exp=00000084", a1); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    ready = 1'b1; rv = 1'b1; rpc = 32'hFFFF_FFFC;
    @(negedge clk);
    rv = 1'b0;
    #1;
    total++; if (a1 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre got=%h exp=fffffffc", a1); end
    @(negedge clk);
    ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h0000_0000 || a0 !== 32'h0000_0000) begin bad++; $display("FAIL wrap got=%h/%h exp=00000000", a1, a0); end
  endtask

`ifdef PC_MISALIGN_CHK_EN
  task automatic test_misalign();
    @(negedge clk);
    ready = 1'b1; rv = 1'b1; rpc = 32'h4000_0101;
    #1;
    total++; if (m1 !== 1'b0) begin bad++; $display("FAIL mis_pre got=%b exp=0", m1); end
    @(negedge clk);
    rv = 1'b0; ready = 1'b0;
    #1;
    total++; if (m1 !== 1'b1 || ma1 !== 32'h4000_0101) begin bad++; $display("FAIL mis_pulse got=%b/%h exp=1/40000101", m1, ma1); end
    total++; if (a1 !== 32'h0000_0004 || a0 !== 32'h0000_0004) begin bad++; $display("FAIL mis_seq got=%h/%h exp=00000004", a1, a0); end
    @(negedge clk); #1;
    total++; if (m1 !== 1'b0 || m0 !== 1'b0) begin bad++; $display("FAIL mis_once got=%b/%b exp=0", m1, m0); end
    @(negedge clk);
    ready = 1'b1; tv = 1'b1; tpc = 32'h0000_0081;
    @(negedge clk);
    tv = 1'b0; ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h0000_0080 || m1 !== 1'b0) begin bad++; $display("FAIL mis_trap got=%h/%b exp=00000080/0", a1, m1); end
  endtask
`else
  task automatic test_align();
    @(negedge clk);
    ready = 1'b1; rv = 1'b1; rpc = 32'h4000_0003;
    @(negedge clk);
    rv = 1'b0; ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h4000_0002) begin bad++; $display("FAIL align_c1 got=%h exp=40000002", a1); end
    total++; if (a0 !== 32'h4000_0000) begin bad++; $display("FAIL align_c0 got=%h exp=40000000", a0); end
    @(negedge clk);
    ready = 1'b1; tv = 1'b1; tpc = 32'h0000_0083;
    @(negedge clk);
    tv = 1'b0; ready = 1'b0;
    #1;
    total++; if (a1 !== 32'h0000_0082 || a0 !== 32'h0000_0080) begin bad++; $display("FAIL align_trap got=%h/%h exp=00000082/00000080", a1, a0); end
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    ready = 1'b1; rv = 1'b1; rpc = 32'h4000_0500;
    @(negedge clk);
    rv = 1'b0; ready = 1'b0;
    @(negedge clk);
    ready = 1'b1; rst = 1'b1;
    #1;
    total++; if (v1 !== 1'b0 || k1 !== 1'b0 || p1 !== 32'h4000_0000) begin bad++; $display("FAIL rst_mid got=%b/%b/%h exp=0/0/40000000", v1, k1, p1); end
    @(negedge clk);
    rst = 1'b0; ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_inc_half();
    test_pending_kill();
    test_trap_idle();
    test_pending_trap();
    test_wrap();
`ifdef PC_MISALIGN_CHK_EN
    test_misalign();
`else
    test_align();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
